video_frame_stat: RTL and testbench

Frame statistics monitor placed directly downstream of `filter_median_5x5`. It consumes the filter's `do_o/de_o/hs_o/vs_o` stream and forwards it unchanged after a one-cycle register. Per frame it measures active width and height, pixel sum, minimum and maximum, and a geometry error flag. It publishes these as a result set with a one-cycle valid strobe at frame end, for the bench monitor and for downstream auto-exposure logic.

---
 rtl/video_stat_pkg.sv | 15 +
 rtl/video_sync_edge.sv | 29 ++
 rtl/video_frame_stat.sv | 149 ++++++++++++++
 tb/tb_video_frame_stat.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_stat_pkg.sv
// Shared types and width helpers for the video frame statistics monitor.
package video_stat_pkg;

    typedef enum logic {IDLE, FRAME} state_t;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Sum width covers PIXEL_MAX * LINE_SIZE_MAX * FRAME_LINES_MAX, so no saturation.
    function automatic int sum_w(input int pix_w, input int line_max, input int frame_max);
        return pix_w + cnt_w(line_max) + cnt_w(frame_max);
    endfunction

endpackage

// File: rtl/video_sync_edge.sv
// Registers a sync signal and flags its rising/falling edges.
module video_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;
    logic armed;

    // No edge is reported on the first sample after reset: there is no prior value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= RST_VAL;
            armed <= 1'b0;
        end else begin
            prev  <= sig;
            armed <= 1'b1;
        end
    end

    assign rise = armed &  sig & ~prev;
    assign fall = armed & ~sig &  prev;

endmodule

// File: rtl/video_frame_stat.sv
// Frame statistics monitor: registered pass-through plus per-frame geometry/pixel stats.
module video_frame_stat
    import video_stat_pkg::*;
#(
    parameter  int PIXEL_WIDTH     = 8,
    parameter  int LINE_SIZE_MAX   = 4096,
    parameter  int FRAME_LINES_MAX = 4096,
    localparam int W_W = cnt_w(LINE_SIZE_MAX),
    localparam int H_W = cnt_w(FRAME_LINES_MAX),
    localparam int S_W = sum_w(PIXEL_WIDTH, LINE_SIZE_MAX, FRAME_LINES_MAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic [W_W-1:0]         stat_width,
    output logic [H_W-1:0]         stat_height,
    output logic [S_W-1:0]         stat_sum,
    output logic [PIXEL_WIDTH-1:0] stat_min,
    output logic [PIXEL_WIDTH-1:0] stat_max,
    output logic                   stat_err,
    output logic                   stat_vld,
    output logic [15:0]            frame_cnt
);

    typedef struct packed {
        logic [W_W-1:0]         width;
        logic [H_W-1:0]         height;
        logic [S_W-1:0]         sum;
        logic [PIXEL_WIDTH-1:0] min;
        logic [PIXEL_WIDTH-1:0] max;
        logic                   err;
    } video_stat_t;

    localparam video_stat_t ACC_CLR = '{width: '0, height: '0, sum: '0,
                                        min: '1, max: '0, err: 1'b0};

    logic        hs_rise, hs_fall_unused, vs_rise, vs_fall;
    state_t      state;
    video_stat_t acc, nxt, stat_q;
    logic [W_W-1:0] pix_cnt, pix_nxt;
    logic        first, first_nxt;

    video_sync_edge #(.RST_VAL(1'b1)) u_hs_edge (
        .clk(clk), .rst(rst), .sig(hs_i), .rise(hs_rise), .fall(hs_fall_unused));

    video_sync_edge #(.RST_VAL(1'b0)) u_vs_edge (
        .clk(clk), .rst(rst), .sig(vs_i), .rise(vs_rise), .fall(vs_fall));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            do_o <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b1;
            vs_o <= 1'b0;
        end else begin
            do_o <= di_i;
            de_o <= de_i;
            hs_o <= hs_i;
            vs_o <= vs_i;
        end
    end

    // One cycle of accumulation: start-of-frame clear, pixel, then line close.
    always_comb begin
        nxt       = acc;
        pix_nxt   = pix_cnt;
        first_nxt = first;
        if (vs_rise) begin
            nxt       = ACC_CLR;
            pix_nxt   = '0;
            first_nxt = 1'b1;
        end
        if (de_i) begin
            if (hs_i || !vs_i || pix_nxt == W_W'(LINE_SIZE_MAX)) begin
                nxt.err = 1'b1;
            end else begin
                pix_nxt = pix_nxt + 1'b1;
                nxt.sum = nxt.sum + S_W'(di_i);
                if (di_i < nxt.min) nxt.min = di_i;
                if (di_i > nxt.max) nxt.max = di_i;
            end
        end
        // A falling vs also closes a still-open line, so no line is lost.
        if ((hs_rise || vs_fall) && pix_nxt != '0) begin
            if (nxt.height == H_W'(FRAME_LINES_MAX)) begin
                nxt.err = 1'b1;
            end else begin
                if (first_nxt) begin
                    nxt.width = pix_nxt;
                    first_nxt = 1'b0;
                end else if (pix_nxt != nxt.width) begin
                    nxt.err = 1'b1;
                end
                nxt.height = nxt.height + 1'b1;
            end
            pix_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            pix_cnt   <= '0;
            first     <= 1'b0;
            stat_q    <= '0;
            stat_vld  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            stat_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        acc     <= nxt;
                        pix_cnt <= pix_nxt;
                        first   <= first_nxt;
                        state   <= FRAME;
                    end
                end
                FRAME: begin
                    acc     <= nxt;
                    pix_cnt <= pix_nxt;
                    first   <= first_nxt;
                    if (vs_fall) begin
                        stat_q    <= nxt;
                        stat_vld  <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign stat_width  = stat_q.width;
    assign stat_height = stat_q.height;
    assign stat_sum    = stat_q.sum;
    assign stat_min    = stat_q.min;
    assign stat_max    = stat_q.max;
    assign stat_err    = stat_q.err;

endmodule

// File: tb/tb_video_frame_stat.sv
// Randomized + directed bench for video_frame_stat against a frame-level behavioural model.
module tb_video_frame_stat;

    localparam int PW   = 8;
    localparam int LMAX = 16;
    localparam int HMAX = 10;
    localparam int W_W  = $clog2(LMAX + 1);
    localparam int H_W  = $clog2(HMAX + 1);
    localparam int S_W  = PW + W_W + H_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] di_i = '0;
    logic          de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b0;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o;
    logic [W_W-1:0] stat_width;
    logic [H_W-1:0] stat_height;
    logic [S_W-1:0] stat_sum;
    logic [PW-1:0]  stat_min, stat_max;
    logic           stat_err, stat_vld;
    logic [15:0]    frame_cnt;

    always #5 clk = ~clk;

    video_frame_stat #(.PIXEL_WIDTH(PW), .LINE_SIZE_MAX(LMAX), .FRAME_LINES_MAX(HMAX)) dut (
        .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .stat_width(stat_width), .stat_height(stat_height), .stat_sum(stat_sum),
        .stat_min(stat_min), .stat_max(stat_max), .stat_err(stat_err),
        .stat_vld(stat_vld), .frame_cnt(frame_cnt));

    int n_cmp = 0;
    int n_bad = 0;
    int vld_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frames as lists of lines and pixels ----------------
    bit      m_have, m_pvs, m_phs, m_in, m_err;
    int      m_cur;
    int      m_lines[$];
    int      m_pix[$];
    logic [PW-1:0] e_do = '0;
    bit      e_de = 0, e_hs = 1, e_vs = 0, e_vld = 0, e_err = 0;
    int      e_w = 0, e_h = 0, e_sum = 0, e_min = 0, e_max = 0, e_fc = 0;
    bit      vr, vf, hr;
    int      nl;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_have = 0; m_in = 0;
            e_do = '0; e_de = 0; e_hs = 1; e_vs = 0; e_vld = 0;
            e_w = 0; e_h = 0; e_sum = 0; e_min = 0; e_max = 0; e_err = 0; e_fc = 0;
        end else begin
            vr = m_have && vs_i && !m_pvs;
            vf = m_have && !vs_i && m_pvs;
            hr = m_have && hs_i && !m_phs;
            e_do = di_i; e_de = de_i; e_hs = hs_i; e_vs = vs_i; e_vld = 0;
            if (vr) begin
                m_in = 1; m_cur = 0; m_err = 0;
                m_lines.delete(); m_pix.delete();
            end
            if (m_in) begin
                if (de_i) begin
                    if (hs_i || !vs_i || m_cur == LMAX) m_err = 1;
                    else begin m_cur++; m_pix.push_back(int'(di_i)); end
                end
                if ((hr || vf) && m_cur > 0) begin
                    m_lines.push_back(m_cur);
                    m_cur = 0;
                end
                if (vf) begin
                    nl = (m_lines.size() > HMAX) ? HMAX : m_lines.size();
                    if (m_lines.size() > HMAX) m_err = 1;
                    e_w = (nl > 0) ? m_lines[0] : 0;
                    for (int i = 0; i < nl; i++) if (m_lines[i] != m_lines[0]) m_err = 1;
                    e_h = nl; e_sum = 0; e_min = (1 << PW) - 1; e_max = 0;
                    foreach (m_pix[i]) begin
                        e_sum += m_pix[i];
                        if (m_pix[i] < e_min) e_min = m_pix[i];
                        if (m_pix[i] > e_max) e_max = m_pix[i];
                    end
                    e_err = m_err; e_vld = 1; e_fc = (e_fc + 1) & 16'hFFFF;
                    m_in = 0;
                end
            end
            m_have = 1; m_pvs = vs_i; m_phs = hs_i;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("passthru", {do_o, de_o, hs_o, vs_o}, {e_do, e_de, e_hs, e_vs});
        check("stat_vld", stat_vld, e_vld);
        check("frame_cnt", frame_cnt, e_fc);
        check("stats", {stat_width, stat_height, stat_sum, stat_min, stat_max, stat_err},
              {W_W'(e_w), H_W'(e_h), S_W'(e_sum), PW'(e_min), PW'(e_max), e_err});
        if (stat_vld) vld_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit de, input bit hs, input bit vs, input int d);
        @(negedge clk); #1;
        de_i = de; hs_i = hs; vs_i = vs; di_i = PW'(d);
    endtask

    task automatic reset_dut();
        @(negedge clk); #1;
        rst = 0; de_i = 0; hs_i = 1; vs_i = 0; di_i = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1;
    endtask

    // gap: 0 none, 1 every other cycle, 2 random; endm: 0 normal, 1 vs falls with hs rise, 2 vs falls mid-line
    task automatic frame(input int w, input int h, input int short_y, input int short_len,
                         input int gap, input bit rnd, input int endm, input bit stray);
        int len;
        repeat (3) drv(0, 1, 0, 0);
        repeat (2) drv(0, 1, 1, 0);
        for (int y = 0; y < h; y++) begin
            len = (y == short_y) ? short_len : w;
            for (int x = 0; x < len; x++) begin
                if (gap == 1 && x > 0) drv(0, 0, 1, 0);
                if (gap == 2 && $urandom_range(3) == 0) drv(0, 0, 1, 0);
                drv(1, 0, 1, rnd ? int'($urandom_range(255)) : x + y);
            end
            if (y == h - 1 && endm == 1) drv(0, 1, 0, 0);
            else if (y == h - 1 && endm == 2) drv(0, 0, 0, 0);
            else begin
                drv(0, 1, 1, 0);
                if (stray && $urandom_range(7) == 0) drv(1, 1, 1, int'($urandom_range(255)));
                drv(0, 1, 1, 0);
            end
        end
        repeat (3) drv(0, 1, 0, 0);
    endtask

    task automatic pin(input string nm, input int w, input int h, input int s,
                       input int mn, input int mx, input bit er);
        check({nm, "_width"},  stat_width,  w);
        check({nm, "_height"}, stat_height, h);
        check({nm, "_sum"},    stat_sum,    s);
        check({nm, "_min"},    stat_min,    mn);
        check({nm, "_max"},    stat_max,    mx);
        check({nm, "_err"},    stat_err,    er);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1;

        // 16x8, pixel = x+y: sum = 8*120 + 16*28 = 1408
        base = vld_cnt;
        frame(16, 8, -1, 0, 0, 0, 0, 0);
        pin("t1", 16, 8, 1408, 0, 22, 0);
        check("t1_vld_cnt", vld_cnt - base, 1);
        check("t1_frame_cnt", frame_cnt, 1);

        reset_dut();
        base = vld_cnt;
        frame(16, 8, -1, 0, 1, 0, 0, 0);
        pin("t2a", 16, 8, 1408, 0, 22, 0);
        frame(16, 8, -1, 0, 1, 0, 0, 0);
        pin("t2b", 16, 8, 1408, 0, 22, 0);
        check("t2_frame_cnt", frame_cnt, 2);

        // line 3 short by one pixel (value 15+3 missing)
        frame(16, 8, 3, 15, 0, 0, 0, 0);
        pin("t3", 16, 8, 1390, 0, 22, 1);

        base = vld_cnt;
        frame(16, 8, -1, 0, 0, 0, 1, 0);
        pin("t4", 16, 8, 1408, 0, 22, 0);
        check("t4_vld_cnt", vld_cnt - base, 1);

        // reset mid-line, released while vs is still high
        reset_dut();
        base = vld_cnt;
        repeat (2) drv(0, 1, 0, 0);
        repeat (2) drv(0, 1, 1, 0);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 16; x++) drv(1, 0, 1, x + y);
            drv(0, 1, 1, 0);
        end
        for (int x = 0; x < 6; x++) drv(1, 0, 1, x);
        @(negedge clk); #1 rst = 0;
        repeat (3) drv(1, 0, 1, 7);
        @(negedge clk); #1 rst = 1;
        repeat (4) drv(1, 0, 1, 5);
        drv(0, 1, 1, 0);
        repeat (3) drv(0, 1, 0, 0);
        check("t5_partial_vld", vld_cnt - base, 0);
        frame(16, 8, -1, 0, 0, 0, 0, 0);
        pin("t5", 16, 8, 1408, 0, 22, 0);
        check("t5_vld_cnt", vld_cnt - base, 1);
        check("t5_frame_cnt", frame_cnt, 1);

        // 17-pixel line: 17th pixel dropped
        frame(17, 1, -1, 0, 0, 0, 0, 0);
        pin("t6", 16, 1, 120, 0, 15, 1);
        frame(0, 0, -1, 0, 0, 0, 0, 0);
        pin("t6_empty", 0, 0, 0, 255, 0, 0);

        // 11 lines of 4 with HMAX=10: all pixels summed, height saturates
        frame(4, 11, -1, 0, 0, 0, 2, 0);
        pin("t7", 4, 10, 286, 0, 13, 1);

        for (int f = 0; f < 30; f++) begin
            int w, h, sy;
            w  = ($urandom_range(5) == 0) ? LMAX + 1 : int'($urandom_range(1, LMAX));
            h  = int'($urandom_range(0, HMAX + 1));
            sy = ($urandom_range(2) == 0) ? int'($urandom_range(0, HMAX)) : -1;
            frame(w, h, sy, int'($urandom_range(0, LMAX + 1)), int'($urandom_range(2)), 1,
                  int'($urandom_range(2)), 1);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
